// File: rtl/seq_register_writeback.sv
// Write-back stage register: drives the register-file write port one cycle after execute
// and forwards the two most recent committed writes to the read-stage operands.
module seq_register_writeback #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned REG_ADDR  = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sys_halt,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic                 i_write_en,
    input  logic [REG_ADDR-1:0]  i_destination,
    input  logic [DATA_SIZE-1:0] i_result,
    input  logic [15:0]          i_instruction,
    input  logic [REG_ADDR-1:0]  i_src1,
    input  logic [REG_ADDR-1:0]  i_src2,
    input  logic                 i_read_operand1,
    input  logic                 i_read_operand2,
    input  logic [DATA_SIZE-1:0] i_rf_operand1,
    input  logic [DATA_SIZE-1:0] i_rf_operand2,
    output logic                 o_wr_en,
    output logic [REG_ADDR-1:0]  o_wr_addr,
    output logic [DATA_SIZE-1:0] o_wr_data,
    output logic [15:0]          o_instruction,
    output logic [DATA_SIZE-1:0] o_operand1,
    output logic [DATA_SIZE-1:0] o_operand2,
    output logic [1:0]           o_fwd1,
    output logic [1:0]           o_fwd2,
    output logic [15:0]          o_commit_count
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic                 wr_en;
        logic [REG_ADDR-1:0]  addr;
        logic [DATA_SIZE-1:0] data;
        logic [INSTR_W-1:0]   instr;
    } wb_entry_t;

    typedef struct packed {
        logic                 wr_en;
        logic [REG_ADDR-1:0]  addr;
        logic [DATA_SIZE-1:0] data;
    } hist_entry_t;

    typedef struct packed {
        logic [1:0]           sel;
        logic [DATA_SIZE-1:0] data;
    } fwd_t;

    wb_entry_t          e0_q, e0_d;
    hist_entry_t        e1_q, e1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    fwd_t               fwd1, fwd2;

    // Next state: halt freezes everything (even over flush); flush squashes the capture.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (!i_sys_halt) begin
            e1_d.wr_en = e0_q.wr_en;
            e1_d.addr  = e0_q.addr;
            e1_d.data  = e0_q.data;
            if (i_flush) begin
                e0_d = '0;
            end else begin
                e0_d.wr_en = i_valid & i_write_en;
                e0_d.addr  = i_destination;
                e0_d.data  = i_result;
                e0_d.instr = i_instruction;
                if (i_valid && i_write_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    // Youngest committed write wins; unused operands always take the register file.
    function automatic fwd_t forward(
        input logic                 rd,
        input logic [REG_ADDR-1:0]  src,
        input logic [DATA_SIZE-1:0] rf,
        input wb_entry_t            e0,
        input hist_entry_t          e1
    );
        fwd_t r;
        r.sel  = 2'd0;
        r.data = rf;
        if (rd) begin
            if (e0.wr_en && (e0.addr == src)) begin
                r.sel  = 2'd1;
                r.data = e0.data;
            end else if (e1.wr_en && (e1.addr == src)) begin
                r.sel  = 2'd2;
                r.data = e1.data;
            end
        end
        return r;
    endfunction

    always_comb begin
        fwd1 = forward(i_read_operand1, i_src1, i_rf_operand1, e0_q, e1_q);
        fwd2 = forward(i_read_operand2, i_src2, i_rf_operand2, e0_q, e1_q);
    end

    assign o_wr_en        = e0_q.wr_en & ~i_sys_halt;
    assign o_wr_addr      = e0_q.addr;
    assign o_wr_data      = e0_q.data;
    assign o_instruction  = e0_q.instr;
    assign o_commit_count = cnt_q;
    assign o_fwd1         = fwd1.sel;
    assign o_operand1     = fwd1.data;
    assign o_fwd2         = fwd2.sel;
    assign o_operand2     = fwd2.data;

endmodule

// File: tb/tb_seq_register_writeback.sv
// Scoreboard bench for seq_register_writeback: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_seq_register_writeback;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_sys_halt, i_flush, i_valid, i_write_en;
    logic [2:0]  i_destination, i_src1, i_src2;
    logic [31:0] i_result, i_rf_operand1, i_rf_operand2;
    logic [15:0] i_instruction;
    logic        i_read_operand1, i_read_operand2;
    logic        o_wr_en;
    logic [2:0]  o_wr_addr;
    logic [31:0] o_wr_data, o_operand1, o_operand2;
    logic [15:0] o_instruction, o_commit_count;
    logic [1:0]  o_fwd1, o_fwd2;

    seq_register_writeback dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sys_halt(i_sys_halt), .i_flush(i_flush),
        .i_valid(i_valid), .i_write_en(i_write_en), .i_destination(i_destination),
        .i_result(i_result), .i_instruction(i_instruction),
        .i_src1(i_src1), .i_src2(i_src2),
        .i_read_operand1(i_read_operand1), .i_read_operand2(i_read_operand2),
        .i_rf_operand1(i_rf_operand1), .i_rf_operand2(i_rf_operand2),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_instruction(o_instruction), .o_operand1(o_operand1), .o_operand2(o_operand2),
        .o_fwd1(o_fwd1), .o_fwd2(o_fwd2), .o_commit_count(o_commit_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          tag;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [15:0] instr;
        logic [1:0]  f1;
        logic [31:0] o1;
        logic [1:0]  f2;
        logic [31:0] o2;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic cmp(input int tag, input string what, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL step%0d %s: actual=%h required=%h", tag, what, act, req);
        end
    endtask

    // Monitor: one expectation per falling edge, well away from the rising edge.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.tag, "wr_en",  32'(o_wr_en),        32'(e.we));
            cmp(e.tag, "wr_addr", 32'(o_wr_addr),     32'(e.addr));
            cmp(e.tag, "wr_data", o_wr_data,          e.data);
            cmp(e.tag, "instr",  32'(o_instruction),  32'(e.instr));
            cmp(e.tag, "fwd1",   32'(o_fwd1),         32'(e.f1));
            cmp(e.tag, "operand1", o_operand1,        e.o1);
            cmp(e.tag, "fwd2",   32'(o_fwd2),         32'(e.f2));
            cmp(e.tag, "operand2", o_operand2,        e.o2);
            cmp(e.tag, "commit_count", 32'(o_commit_count), 32'(e.cnt));
        end
    end

    task automatic push(input int tag, input logic we, input logic [2:0] addr, input logic [31:0] data,
                        input logic [15:0] instr, input logic [1:0] f1, input logic [31:0] o1,
                        input logic [1:0] f2, input logic [31:0] o2, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.we = we; e.addr = addr; e.data = data; e.instr = instr;
        e.f1 = f1; e.o1 = o1; e.f2 = f2; e.o2 = o2; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_valid = 1'b0; i_write_en = 1'b0; i_destination = 3'd0;
        i_result = 32'd0; i_instruction = 16'd0; i_flush = 1'b0; i_sys_halt = 1'b0;
    endtask

    task automatic wr(input logic [2:0] d, input logic [31:0] r, input logic [15:0] ins);
        i_valid = 1'b1; i_write_en = 1'b1; i_destination = d; i_result = r; i_instruction = ins;
        i_flush = 1'b0; i_sys_halt = 1'b0;
    endtask

    localparam logic [31:0] RF1 = 32'h11;
    localparam logic [31:0] RF2 = 32'h22;

    initial begin
        i_rst = 1'b1;
        idle();
        i_src1 = 3'd0; i_src2 = 3'd0;
        i_read_operand1 = 1'b0; i_read_operand2 = 1'b0;
        i_rf_operand1 = RF1; i_rf_operand2 = RF2;
        push(1, 0, 0, 0, 0, 0, RF1, 0, RF2, 0);
        tick();
        i_rst = 1'b0;

        // basic write-back
        wr(3'd3, 32'hDEADBEEF, 16'h1003);
        tick(); idle();
        push(2, 1, 3, 32'hDEADBEEF, 16'h1003, 0, RF1, 0, RF2, 1);
        tick();
        push(3, 0, 0, 0, 0, 0, RF1, 0, RF2, 1);

        // forward priority: r2=5 then r2=9
        wr(3'd2, 32'd5, 16'h2005);
        tick();
        wr(3'd2, 32'd9, 16'h2009);
        tick(); idle();
        i_src1 = 3'd2; i_read_operand1 = 1'b1;
        i_src2 = 3'd2; i_read_operand2 = 1'b0;
        push(4, 1, 2, 32'd9, 16'h2009, 1, 32'd9, 0, RF2, 3);
        tick();
        i_read_operand2 = 1'b1;
        push(5, 0, 0, 0, 0, 2, 32'd9, 2, 32'd9, 3);

        // flush a valid write to r4
        tick();
        push(6, 0, 0, 0, 0, 0, RF1, 0, RF2, 3);
        wr(3'd4, 32'd7, 16'h4007);
        i_flush = 1'b1;
        i_src1 = 3'd4;
        tick(); idle();
        i_read_operand2 = 1'b0;
        push(7, 0, 0, 0, 0, 0, RF1, 0, RF2, 3);

        // halt over three edges with new inputs and flush asserted
        wr(3'd1, 32'h55, 16'h1055);
        tick();
        wr(3'd6, 32'h66, 16'h6066);
        i_flush = 1'b1; i_sys_halt = 1'b1;
        i_src1 = 3'd1; i_read_operand1 = 1'b1;
        push(8, 0, 1, 32'h55, 16'h1055, 1, 32'h55, 0, RF2, 4);
        tick();
        push(9, 0, 1, 32'h55, 16'h1055, 1, 32'h55, 0, RF2, 4);
        tick();
        push(10, 0, 1, 32'h55, 16'h1055, 1, 32'h55, 0, RF2, 4);
        tick(); idle();
        i_src2 = 3'd0; i_read_operand2 = 1'b1;
        push(11, 1, 1, 32'h55, 16'h1055, 1, 32'h55, 0, RF2, 4);
        tick();
        push(12, 0, 0, 0, 0, 2, 32'h55, 0, RF2, 4);

        // async reset between edges
        i_read_operand2 = 1'b0;
        wr(3'd5, 32'hAA, 16'h50AA);
        tick(); idle();
        i_sys_halt = 1'b1;
        push(13, 0, 5, 32'hAA, 16'h50AA, 0, RF1, 0, RF2, 5);
        tick();
        i_sys_halt = 1'b0;
        i_rst = 1'b1;
        push(14, 0, 0, 0, 0, 0, RF1, 0, RF2, 0);
        tick();
        i_rst = 1'b0;

        // counter wrap
        i_read_operand1 = 1'b0;
        wr(3'd7, 32'h1234, 16'h7000);
        repeat (65535) tick();
        push(15, 1, 7, 32'h1234, 16'h7000, 0, RF1, 0, RF2, 16'hFFFF);
        tick(); idle();
        push(16, 1, 7, 32'h1234, 16'h7000, 0, RF1, 0, RF2, 16'h0000);
        tick();
        i_src1 = 3'd7; i_read_operand1 = 1'b1;
        push(17, 0, 0, 0, 0, 2, 32'h1234, 0, RF2, 16'h0000);

        // bounded drain of the scoreboard
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge i_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
